bram_access_ctrl: RTL and testbench
===================================

Name: bram_access_ctrl

Overview:
- Shares one 4096 x 18 block RAM (combinational read, write on the clock edge) between NREQ requesters using a round-robin arbiter.
- Adds a hardware clear engine that zeroes the whole array by sweeping addresses, replacing the RAM's costly 4096-entry reset loop.
- Sits between the solver's clause/assignment engines and the RAM instance; it is the only driver of the RAM control pins.

Parameters:
NREQ, 2, number of requesters (2..4)
DBUS, 18, data width
ABUS, 12, address width; array depth = 2**ABUS

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
CLR_START  in  1  one-cycle pulse: start full-array clear
CLR_BUSY  out  1  high while the clear sweep runs
REQ  in  NREQ  per-requester access request (level)
REQ_WR  in  NREQ  1 = write, 0 = read, per requester
REQ_ADDR  in  NREQ*ABUS  packed addresses; requester i at [i*ABUS +: ABUS]
REQ_WDATA  in  NREQ*DBUS  packed write data; requester i at [i*DBUS +: DBUS]
GNT  out  NREQ  one-hot grant; the access executes in the cycle GNT is high
RDATA  out  DBUS  registered read data (shared by all requesters)
RVALID  out  NREQ  one-hot: RDATA belongs to requester i
BRAM_EN  out  1  RAM enable
BRAM_READ  out  1  RAM read strobe
BRAM_WRITE  out  1  RAM write strobe
BRAM_ADDR  out  ABUS  RAM address
BRAM_DIN  out  DBUS  RAM write data
BRAM_DOUT  in  DBUS  RAM combinational read data

Behaviour:
- Reset (async, RST=1): state=ARB, rr_ptr=0, clr_cnt=0, RDATA=0, RVALID=0, CLR_BUSY=0. GNT=0 and all BRAM_* outputs=0 while RST is high. RAM contents are not touched.
- States: ARB (normal arbitration) and CLEAR (sweep).
- ARB, grant:
  - Combinational, same cycle as REQ.
  - Search starts at rr_ptr and wraps modulo NREQ; first requester with REQ=1 gets GNT.
  - At most one GNT bit is set. With no REQ, GNT=0 and BRAM_EN=0.
- ARB, RAM drive for granted requester g:
  - BRAM_EN=1, BRAM_ADDR=addr[g].
  - Read: BRAM_READ=1, BRAM_WRITE=0, BRAM_DIN=0.
  - Write: BRAM_WRITE=1, BRAM_READ=0, BRAM_DIN=wdata[g].
- rr_ptr update: on a clock edge with a grant, rr_ptr <= (g+1) mod NREQ; otherwise unchanged.
- Read latency 1: on the edge ending a granted read, RDATA <= BRAM_DOUT and RVALID <= onehot(g).
- Otherwise RVALID <= 0 and RDATA holds its last value.
- Write data lands in the RAM on the edge ending the grant cycle. A read granted in the next cycle returns the new data.
- Requester protocol:
  - Holds REQ, REQ_WR, REQ_ADDR and REQ_WDATA stable until it sees GNT.
  - One access per GNT cycle. REQ still high after GNT counts as a new request.
- CLR_START in ARB:
  - The arbiter still grants a requester in that same cycle.
  - On the edge, state <= CLEAR, clr_cnt <= 0, CLR_BUSY <= 1.
- CLEAR:
  - GNT=0 regardless of REQ. BRAM_EN=1, BRAM_WRITE=1, BRAM_READ=0, BRAM_ADDR=clr_cnt, BRAM_DIN=0.
  - clr_cnt increments each cycle.
  - In the cycle with clr_cnt = 2**ABUS-1, the last write occurs. On that edge state <= ARB, CLR_BUSY <= 0, clr_cnt <= 0.
  - Sweep length is exactly 4096 cycles. CLR_START during CLEAR is ignored (no restart).
- Pending requests wait through the clear and are served round-robin from the unchanged rr_ptr afterwards.
- RST mid-clear: the sweep aborts immediately and the RAM is left partially cleared. Software must reissue CLR_START.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> GNT=0, RVALID=0, RDATA=0, CLR_BUSY=0, BRAM_EN=0 immediately, without waiting for a clock edge.
- Write/read, single requester: req0 writes 0x2ABCD to addr 0x123; next cycle req0 reads 0x123 -> GNT[0] in each request cycle, RVALID=01 and RDATA=0x2ABCD one cycle after the read grant.
- Contention: REQ=11 held for 4 cycles, rr_ptr=0 -> grant sequence 01,10,01,10. REQ=10 alone -> GNT=10 and rr_ptr becomes 0.
- Clear: preload addrs 0, 0x7FF and 0xFFF with nonzero data; pulse CLR_START -> CLR_BUSY high exactly 4096 cycles; reads of 0, 0x7FF and 0xFFF afterwards return 0.
- Clear with pending request and restart pulse: REQ=01 held during the sweep and CLR_START pulsed at cycle 100 -> GNT stays 0 and the sweep does not restart; GNT[0] in the first cycle after CLR_BUSY falls.
- Reset mid-clear: RST at cycle 2000 of the sweep -> CLR_BUSY=0 and state ARB. Addr 0x7CF reads 0, addr 0x7D0 keeps its preload value 0x15555.

Source files
------------

// File: rtl/bram_access_ctrl.sv
// bram_access_ctrl: round-robin arbiter sharing one block RAM among NREQ requesters,
// plus a sweep engine that zeroes the whole array one address per cycle.
module bram_access_ctrl #(
    parameter int NREQ = 2,
    parameter int DBUS = 18,
    parameter int ABUS = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR_START,
    output logic                 CLR_BUSY,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      REQ_WR,
    input  logic [NREQ*ABUS-1:0] REQ_ADDR,
    input  logic [NREQ*DBUS-1:0] REQ_WDATA,
    output logic [NREQ-1:0]      GNT,
    output logic [DBUS-1:0]      RDATA,
    output logic [NREQ-1:0]      RVALID,
    output logic                 BRAM_EN,
    output logic                 BRAM_READ,
    output logic                 BRAM_WRITE,
    output logic [ABUS-1:0]      BRAM_ADDR,
    output logic [DBUS-1:0]      BRAM_DIN,
    input  logic [DBUS-1:0]      BRAM_DOUT
);
    localparam int PW = (NREQ > 2) ? 2 : 1;
    typedef enum logic {ARB, CLEAR} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, g;
    logic [ABUS-1:0] clr_cnt_q, clr_cnt_d;
    logic [DBUS-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d, gnt;
    logic            found;
    int              idx;
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                g     = PW'(idx);
            end
        end
        found = found && (state_q == ARB);
        if (found) gnt[g] = 1'b1;
    end
    // RST gates the RAM pins combinationally so nothing is driven while reset is held
    always_comb begin
        GNT        = RST ? '0 : gnt;
        BRAM_EN    = !RST && (state_q == CLEAR || found);
        BRAM_WRITE = !RST && (state_q == CLEAR || (found && REQ_WR[g]));
        BRAM_READ  = !RST && state_q == ARB && found && !REQ_WR[g];
        BRAM_ADDR  = RST ? '0 : state_q == CLEAR ? clr_cnt_q : found ? REQ_ADDR[int'(g)*ABUS +: ABUS] : '0;
        BRAM_DIN   = (!RST && state_q == ARB && found && REQ_WR[g]) ? REQ_WDATA[int'(g)*DBUS +: DBUS] : '0;
        CLR_BUSY   = state_q == CLEAR;
        RDATA      = rdata_q;
        RVALID     = rvalid_q;
    end
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        if (state_q == ARB) begin
            state_d   = CLR_START ? CLEAR : ARB;
            clr_cnt_d = '0;
        end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            state_d   = &clr_cnt_q ? ARB : CLEAR;
        end
        if (found) begin
            rr_ptr_d = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
            rvalid_d = REQ_WR[g] ? '0 : gnt;
            rdata_d  = REQ_WR[g] ? rdata_q : BRAM_DOUT;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb_bram_access_ctrl: directed vector table plus hand sequences for clear and reset corner cases,
// with a behavioural 4096x18 RAM attached to the BRAM pins.
module tb_bram_access_ctrl;
    logic        CLK = 1'b0, RST = 1'b1, CLR_START = 1'b0, CLR_BUSY;
    logic [1:0]  REQ = '0, REQ_WR = '0, GNT, RVALID;
    logic [23:0] REQ_ADDR = '0;
    logic [35:0] REQ_WDATA = '0;
    logic [17:0] RDATA, BRAM_DIN, BRAM_DOUT;
    logic        BRAM_EN, BRAM_READ, BRAM_WRITE;
    logic [11:0] BRAM_ADDR;
    logic [17:0] mem [4096];
    int n_tests = 0, n_fail = 0;

    bram_access_ctrl #(.NREQ(2), .DBUS(18), .ABUS(12)) dut (
        .CLK(CLK), .RST(RST), .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY),
        .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .RDATA(RDATA), .RVALID(RVALID),
        .BRAM_EN(BRAM_EN), .BRAM_READ(BRAM_READ), .BRAM_WRITE(BRAM_WRITE),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT)
    );

    always #5 CLK = ~CLK;
    assign BRAM_DOUT = mem[BRAM_ADDR];
    always @(posedge CLK) if (BRAM_EN && BRAM_WRITE) mem[BRAM_ADDR] <= BRAM_DIN;

    typedef struct {
        logic [1:0]  req, wr;
        logic [11:0] a0, a1;
        logic [17:0] d0, d1;
        logic [1:0]  gnt;
        logic        en, we;
        logic [11:0] addr;
        logic [17:0] din;
        logic [1:0]  rvalid;
        logic [17:0] rdata;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [17:0] d);
        REQ = 2'b01; REQ_WR = 2'b01; REQ_ADDR[11:0] = a; REQ_WDATA[17:0] = d;
        @(posedge CLK); #1;
        REQ = '0; REQ_WR = '0;
    endtask

    task automatic do_read(input string name, input logic [11:0] a, input logic [17:0] exp);
        REQ = 2'b01; REQ_WR = 2'b00; REQ_ADDR[11:0] = a;
        @(negedge CLK);
        chk({name, " gnt"}, 32'(GNT), 32'h1);
        @(posedge CLK); #1;
        chk({name, " rvalid"}, 32'(RVALID), 32'h1);
        chk({name, " rdata"}, 32'(RDATA), 32'(exp));
        REQ = '0;
    endtask

    task automatic start_clear();
        CLR_START = 1'b1;
        @(posedge CLK); #1;
        CLR_START = 1'b0;
    endtask

    initial begin
        int cnt, bad;
        vt[0] = '{2'b01, 2'b01, 12'h123, 12'h000, 18'h2ABCD, 18'h0,     2'b01, 1, 1, 12'h123, 18'h2ABCD, 2'b00, 18'h0};
        vt[1] = '{2'b01, 2'b00, 12'h123, 12'h000, 18'h0,     18'h0,     2'b01, 1, 0, 12'h123, 18'h0,     2'b01, 18'h2ABCD};
        vt[2] = '{2'b10, 2'b10, 12'h000, 12'h456, 18'h0,     18'h11111, 2'b10, 1, 1, 12'h456, 18'h11111, 2'b00, 18'h2ABCD};
        vt[3] = '{2'b11, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b01, 1, 0, 12'h123, 18'h0,     2'b01, 18'h2ABCD};
        vt[4] = '{2'b11, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b10, 1, 0, 12'h456, 18'h0,     2'b10, 18'h11111};
        vt[5] = '{2'b11, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b01, 1, 0, 12'h123, 18'h0,     2'b01, 18'h2ABCD};
        vt[6] = '{2'b11, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b10, 1, 0, 12'h456, 18'h0,     2'b10, 18'h11111};
        vt[7] = '{2'b10, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b10, 1, 0, 12'h456, 18'h0,     2'b10, 18'h11111};
        vt[8] = '{2'b11, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b01, 1, 0, 12'h123, 18'h0,     2'b01, 18'h2ABCD};
        vt[9] = '{2'b00, 2'b00, 12'h123, 12'h456, 18'h0,     18'h0,     2'b00, 0, 0, 12'h000, 18'h0,     2'b00, 18'h2ABCD};

        #3;
        chk("reset gnt", 32'(GNT), 0);
        chk("reset busy", 32'(CLR_BUSY), 0);
        chk("reset en", 32'(BRAM_EN), 0);
        chk("reset rvalid", 32'(RVALID), 0);
        chk("reset rdata", 32'(RDATA), 0);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) begin
            REQ = vt[i].req; REQ_WR = vt[i].wr;
            REQ_ADDR = {vt[i].a1, vt[i].a0}; REQ_WDATA = {vt[i].d1, vt[i].d0};
            @(negedge CLK);
            chk($sformatf("v%0d gnt", i), 32'(GNT), 32'(vt[i].gnt));
            chk($sformatf("v%0d en", i), 32'(BRAM_EN), 32'(vt[i].en));
            chk($sformatf("v%0d we", i), 32'(BRAM_WRITE), 32'(vt[i].we));
            chk($sformatf("v%0d rd", i), 32'(BRAM_READ), 32'(vt[i].en && !vt[i].we));
            chk($sformatf("v%0d addr", i), 32'(BRAM_ADDR), 32'(vt[i].addr));
            chk($sformatf("v%0d din", i), 32'(BRAM_DIN), 32'(vt[i].din));
            @(posedge CLK); #1;
            chk($sformatf("v%0d rvalid", i), 32'(RVALID), 32'(vt[i].rvalid));
            chk($sformatf("v%0d rdata", i), 32'(RDATA), 32'(vt[i].rdata));
        end

        REQ = 2'b01; REQ_WR = 2'b00; REQ_ADDR[11:0] = 12'h123;
        @(posedge CLK); #1;
        chk("pre-arst rvalid", 32'(RVALID), 32'h1);
        #1 RST = 1'b1;
        #1;
        chk("arst gnt", 32'(GNT), 0);
        chk("arst rvalid", 32'(RVALID), 0);
        chk("arst rdata", 32'(RDATA), 0);
        chk("arst en", 32'(BRAM_EN), 0);
        chk("arst busy", 32'(CLR_BUSY), 0);
        REQ = '0;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;

        do_write(12'h000, 18'h00001);
        do_write(12'h7FF, 18'h3FFFF);
        do_write(12'hFFF, 18'h15555);
        do_read("preload fff", 12'hFFF, 18'h15555);
        start_clear();
        cnt = 0;
        while (CLR_BUSY && cnt < 5000) begin
            cnt++;
            @(posedge CLK); #1;
        end
        chk("clear length", 32'(cnt), 4096);
        do_read("clr 000", 12'h000, 18'h0);
        do_read("clr 7ff", 12'h7FF, 18'h0);
        do_read("clr fff", 12'hFFF, 18'h0);

        start_clear();
        cnt = 0; bad = 0;
        while (CLR_BUSY && cnt < 5000) begin
            if (GNT != 0) bad++;
            REQ = 2'b01; REQ_WR = 2'b00; REQ_ADDR[11:0] = 12'h005;
            CLR_START = (cnt == 100);
            cnt++;
            @(posedge CLK); #1;
        end
        CLR_START = 1'b0;
        chk("pend no gnt", 32'(bad), 0);
        chk("pend length", 32'(cnt), 4096);
        chk("pend gnt after", 32'(GNT), 32'h1);
        @(posedge CLK); #1;
        REQ = '0;

        do_write(12'h7CF, 18'h2AAAA);
        do_write(12'h7D0, 18'h15555);
        start_clear();
        cnt = 0;
        while (CLR_BUSY && cnt < 2000) begin
            cnt++;
            @(posedge CLK); #1;
        end
        chk("mid reached", 32'(cnt), 2000);
        RST = 1'b1;
        #1;
        chk("mid busy", 32'(CLR_BUSY), 0);
        chk("mid en", 32'(BRAM_EN), 0);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        chk("mid post busy", 32'(CLR_BUSY), 0);
        do_read("mid 7cf", 12'h7CF, 18'h0);
        do_read("mid 7d0", 12'h7D0, 18'h15555);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
